h264_stream_packer: RTL

//  Downstream of the H.264 I-frame encoder on PIX_CLK. Packs the encoder's 16-bit

---
 rtl/h264_stream_packer.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/h264_stream_packer.sv
// Packs 16-bit H.264 encoder words into 64-bit words, queues them in a show-ahead FIFO
// and closes each frame with a LAST-tagged word plus a byte count once the encoder goes idle.
module h264_stream_packer #(
    parameter int G_FIFO_AW     = 5,
    parameter int G_IDLE_CYCLES = 1024
) (
    input  logic        PIX_CLK,
    input  logic        RESET_N,
    input  logic [15:0] DATA_I,
    input  logic        DATA_VALID_I,
    input  logic        FRAME_END_I,
    output logic [63:0] DATA_O,
    output logic        DATA_VALID_O,
    input  logic        DATA_READY_I,
    output logic        LAST_O,
    output logic [31:0] FRAME_BYTES_O,
    output logic        FRAME_DONE_O,
    output logic        OVERFLOW_O
);
    localparam int                   DEPTH     = 2**G_FIFO_AW;
    localparam logic [31:0]          IDLE_LAST = 32'(G_IDLE_CYCLES - 1);
    localparam logic [G_FIFO_AW-1:0] PTR_ONE   = G_FIFO_AW'(1);
    localparam logic [G_FIFO_AW:0]   CNT_ONE   = (G_FIFO_AW+1)'(1);
    localparam logic [G_FIFO_AW:0]   CNT_FULL  = (G_FIFO_AW+1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_PACK, S_WAIT_IDLE, S_FLUSH} state_t;

    state_t state, state_next;

    logic [1:0]  slot;
    logic [63:0] pack_word;
    logic [15:0] hw_swapped;
    logic [63:0] merged;
    logic        word_done;

    logic        wrd_valid;
    logic [63:0] wrd_data;
    logic [63:0] flush_data;
    logic        flush_remark;
    logic        frame_pushed;

    logic [31:0] idle_cnt;
    logic [31:0] byte_cnt;
    logic [31:0] byte_next;
    logic        close;

    logic [63:0]          mem [DEPTH];
    logic [DEPTH-1:0]     last_mem;
    logic [G_FIFO_AW-1:0] wr_ptr;
    logic [G_FIFO_AW-1:0] rd_ptr;
    logic [G_FIFO_AW-1:0] tail_ptr;
    logic [G_FIFO_AW:0]   fifo_cnt;

    logic        fifo_full, pop, can_write;
    logic        remark, flush_push, flush_ok;
    logic        wrd_push, wrd_ok, wrd_drop, hold_drop;
    logic        push, push_last;
    logic [63:0] push_data;

    assign hw_swapped = {DATA_I[7:0], DATA_I[15:8]};
    assign merged     = pack_word | ({48'd0, hw_swapped} << {slot, 4'b0000});
    assign word_done  = DATA_VALID_I && (slot == 2'd3);

    // The flush port has priority; a completed word waiting behind it is held one deep.
    assign fifo_full  = (fifo_cnt == CNT_FULL);
    assign pop        = DATA_VALID_O && DATA_READY_I;
    assign can_write  = !fifo_full || pop;
    assign tail_ptr   = wr_ptr - PTR_ONE;
    assign remark     = (state == S_FLUSH) && flush_remark && (fifo_cnt > (pop ? CNT_ONE : '0));
    assign flush_push = (state == S_FLUSH) && !remark;
    assign flush_ok   = flush_push && can_write;
    assign wrd_push   = wrd_valid && !flush_push;
    assign wrd_ok     = wrd_push && can_write;
    assign wrd_drop   = wrd_push && !can_write;
    assign hold_drop  = word_done && wrd_valid && flush_push;
    assign push       = flush_ok || wrd_ok;
    assign push_data  = flush_push ? flush_data : wrd_data;
    assign push_last  = flush_push;

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (FRAME_END_I)
                    state_next = S_WAIT_IDLE;
                else if (DATA_VALID_I)
                    state_next = S_PACK;
            end
            S_PACK: begin
                if (FRAME_END_I)
                    state_next = S_WAIT_IDLE;
            end
            S_WAIT_IDLE: begin
                if (!DATA_VALID_I && (idle_cnt == IDLE_LAST))
                    state_next = S_FLUSH;
            end
            S_FLUSH: begin
                if (remark || flush_ok)
                    state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign close = (state == S_WAIT_IDLE) && (state_next == S_FLUSH);

    // Bytes of a dropped word are taken back out so the count reflects delivered data.
    always_comb begin
        byte_next = byte_cnt;
        if (DATA_VALID_I)
            byte_next = (byte_cnt > 32'hFFFF_FFFD) ? 32'hFFFF_FFFF : byte_cnt + 32'd2;
        if (wrd_drop || hold_drop)
            byte_next = (byte_next < 32'd8) ? 32'd0 : byte_next - 32'd8;
    end

    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= S_IDLE;
            idle_cnt      <= '0;
            slot          <= '0;
            pack_word     <= '0;
            wrd_valid     <= 1'b0;
            wrd_data      <= '0;
            flush_data    <= '0;
            flush_remark  <= 1'b0;
            frame_pushed  <= 1'b0;
            byte_cnt      <= '0;
            FRAME_BYTES_O <= '0;
            FRAME_DONE_O  <= 1'b0;
            OVERFLOW_O    <= 1'b0;
        end else begin
            state        <= state_next;
            idle_cnt     <= ((state == S_WAIT_IDLE) && !DATA_VALID_I) ? idle_cnt + 32'd1 : '0;
            FRAME_DONE_O <= close;
            OVERFLOW_O   <= OVERFLOW_O || wrd_drop || hold_drop || (flush_push && !can_write);

            if (close) begin
                slot          <= '0;
                pack_word     <= '0;
                flush_data    <= pack_word;
                flush_remark  <= (slot == 2'd0) && frame_pushed;
                frame_pushed  <= 1'b0;
                byte_cnt      <= '0;
                FRAME_BYTES_O <= byte_cnt;
            end else begin
                byte_cnt <= byte_next;
                if (wrd_ok)
                    frame_pushed <= 1'b1;
                if (DATA_VALID_I) begin
                    slot      <= slot + 2'd1;
                    pack_word <= word_done ? '0 : merged;
                end
            end

            if (word_done && !hold_drop) begin
                wrd_valid <= 1'b1;
                wrd_data  <= merged;
            end else if (wrd_push) begin
                wrd_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge PIX_CLK) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge PIX_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            last_mem <= '0;
        end else begin
            if (push) begin
                last_mem[wr_ptr] <= push_last;
                wr_ptr           <= wr_ptr + PTR_ONE;
            end
            if (remark)
                last_mem[tail_ptr] <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign DATA_VALID_O = (fifo_cnt != '0);
    assign DATA_O       = DATA_VALID_O ? mem[rd_ptr] : '0;
    assign LAST_O       = DATA_VALID_O && last_mem[rd_ptr];

endmodule
